// File: rtl/sram_port_arbiter.sv
// Two-port round-robin front end for the 32x33 OpenRAM macro; optional parity via SRAM_PARITY_EN.
// Latency: grant combinational, command registered, read data visible at grant cycle + 2 + READ_LAT.
// Backpressure: none; one grant per cycle, requesters hold req until their gnt.
module sram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              sram_csb_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W:0]   sram_din,
    input  logic [DATA_W:0]   sram_dout,
    output logic              parity_err
);

    logic              last;
    logic              any_gnt;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              spare_bit;
    logic [READ_LAT:0] tag_vld;
    logic [READ_LAT:0] tag_port;

    // Contention goes to the port that did not win last; last resets to 1 so port 0 wins first.
    always_comb begin
        r0_gnt    = r0_req && (!r1_req || last);
        r1_gnt    = r1_req && (!r0_req || !last);
        any_gnt   = r0_gnt || r1_gnt;
        sel       = r1_gnt;
        sel_we    = sel ? r1_we    : r0_we;
        sel_addr  = sel ? r1_addr  : r0_addr;
        sel_wdata = sel ? r1_wdata : r0_wdata;
    end

`ifdef SRAM_PARITY_EN
    assign spare_bit = ^sel_wdata;
`else
    assign spare_bit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last       <= 1'b1;
            sram_csb_n <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_addr  <= '0;
            sram_din   <= '0;
        end else if (any_gnt) begin
            last       <= sel;
            sram_csb_n <= 1'b0;
            sram_we_n  <= ~sel_we;
            sram_addr  <= sel_addr;
            sram_din   <= {spare_bit, sel_wdata};
        end else begin
            sram_csb_n <= 1'b1;
            sram_we_n  <= 1'b1;
        end
    end

    // Stage READ_LAT lines up with the edge on which the macro's dout is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld  <= '0;
            tag_port <= '0;
        end else begin
            tag_vld  <= {tag_vld[READ_LAT-1:0],  any_gnt && !sel_we};
            tag_port <= {tag_port[READ_LAT-1:0], sel};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= tag_vld[READ_LAT] && !tag_port[READ_LAT];
            r1_rvalid <= tag_vld[READ_LAT] &&  tag_port[READ_LAT];
            if (tag_vld[READ_LAT] && !tag_port[READ_LAT])
                r0_rdata <= sram_dout[DATA_W-1:0];
            if (tag_vld[READ_LAT] && tag_port[READ_LAT])
                r1_rdata <= sram_dout[DATA_W-1:0];
        end
    end

`ifdef SRAM_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else if (tag_vld[READ_LAT] && (^sram_dout))
            parity_err <= 1'b1;
    end
`else
    logic spare_unused;
    assign spare_unused = sram_dout[DATA_W];
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: grant vector table, read-return scoreboard, reset and parity sequences.
module tb_sram_port_arbiter;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          sram_csb_n, sram_we_n, parity_err;
    logic [AW-1:0] sram_addr;
    logic [DW:0]   sram_din, sram_dout;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .sram_csb_n(sram_csb_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Behavioural macro: capture on the edge after the command is registered, one-cycle read.
    logic [DW:0] mem [32];
    logic [DW:0] rd_q = '0;
    logic [DW:0] flip_mask = '0;
    always @(posedge clk) begin
        if (!sram_csb_n) begin
            if (!sram_we_n) mem[sram_addr] <= sram_din;
            else            rd_q <= mem[sram_addr];
        end
    end
    assign sram_dout = rd_q ^ flip_mask;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic par(input logic [DW-1:0] d);
`ifdef SRAM_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard of outstanding reads, fed from observed grants.
    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t           sb [$];
    logic [DW-1:0] ref_mem [32];

    always @(negedge clk) begin
        if (!reset) begin
            sb_t e;
            chk("one_gnt", {63'd0, r0_gnt & r1_gnt}, 64'd0);
            if (r0_rvalid || r1_rvalid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rvalid", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rv_port", {62'd0, r1_rvalid, r0_rvalid}, e.port ? 64'd2 : 64'd1);
                    chk("rdata", {32'd0, e.port ? r1_rdata : r0_rdata}, {32'd0, e.data});
                    chk("rlat", 64'(cyc), 64'(e.due));
                end
            end
            if (r0_gnt) begin
                if (r0_we) ref_mem[r0_addr] = r0_wdata;
                else sb.push_back('{1'b0, ref_mem[r0_addr], cyc + 2 + LAT});
            end
            if (r1_gnt) begin
                if (r1_we) ref_mem[r1_addr] = r1_wdata;
                else sb.push_back('{1'b1, ref_mem[r1_addr], cyc + 2 + LAT});
            end
        end
    end

    typedef struct {
        logic          q0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          q1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1;
    } vec_t;

    function automatic vec_t mk(input logic q0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic q1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, g1);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        r0_req = v.q0; r0_we = v.w0; r0_addr = v.a0; r0_wdata = v.d0;
        r1_req = v.q1; r1_we = v.w1; r1_addr = v.a1; r1_wdata = v.d1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_csb_n"}, {63'd0, sram_csb_n}, 64'd1);
        chk({tag, "_we_n"},  {63'd0, sram_we_n},  64'd1);
        chk({tag, "_addr"},  {59'd0, sram_addr},  64'd0);
        chk({tag, "_din"},   {31'd0, sram_din},   64'd0);
        chk({tag, "_rv"},    {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
        chk({tag, "_rd0"},   {32'd0, r0_rdata},   64'd0);
        chk({tag, "_rd1"},   {32'd0, r1_rdata},   64'd0);
        chk({tag, "_perr"},  {63'd0, parity_err}, 64'd0);
    endtask

    vec_t vt [18];
    vec_t idle, prev;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[0]  = idle;
        vt[1]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            1, 0);
        vt[2]  = mk(1, 0, 5, 0,            0, 0, 0, 0,            1, 0);
        vt[3]  = idle;
        vt[4]  = mk(1, 1, 1, 32'h11111111, 0, 0, 0, 0,            1, 0);
        vt[5]  = mk(0, 0, 0, 0,            1, 1, 2, 32'h22222222, 0, 1);
        vt[6]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            1, 0);
        vt[7]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 1);
        vt[8]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            1, 0);
        vt[9]  = mk(1, 0, 1, 0,            1, 0, 2, 0,            0, 1);
        vt[10] = mk(1, 1, 31, 32'hA5A5A5A5, 0, 0, 0, 0,           1, 0);
        vt[11] = mk(0, 0, 0, 0,            1, 0, 31, 0,           0, 1);
        vt[12] = mk(1, 1, 7, 32'h12345678, 1, 1, 7, 32'h0BADF00D, 1, 0);
        vt[13] = mk(0, 0, 0, 0,            1, 1, 7, 32'h0BADF00D, 0, 1);
        vt[14] = mk(1, 0, 7, 0,            0, 0, 0, 0,            1, 0);
        vt[15] = idle;
        vt[16] = idle;
        vt[17] = idle;

        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_csb_n", {63'd0, sram_csb_n}, 64'd1);
            chk("idle_we_n",  {63'd0, sram_we_n},  64'd1);
            chk("idle_gnt",   {62'd0, r1_gnt, r0_gnt}, 64'd0);
            chk("idle_rv",    {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
            chk("idle_perr",  {63'd0, parity_err}, 64'd0);
        end

        prev = idle;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1 drive(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d_gnt0", i), {63'd0, r0_gnt}, {63'd0, vt[i].g0});
            chk($sformatf("v%0d_gnt1", i), {63'd0, r1_gnt}, {63'd0, vt[i].g1});
            // The previous vector's grant is now on the registered macro command.
            if (prev.g0 || prev.g1) begin
                logic          pw;
                logic [AW-1:0] pa;
                logic [DW-1:0] pd;
                pw = prev.g1 ? prev.w1 : prev.w0;
                pa = prev.g1 ? prev.a1 : prev.a0;
                pd = prev.g1 ? prev.d1 : prev.d0;
                chk($sformatf("v%0d_csb_n", i), {63'd0, sram_csb_n}, 64'd0);
                chk($sformatf("v%0d_we_n", i),  {63'd0, sram_we_n},  {63'd0, ~pw});
                chk($sformatf("v%0d_addr", i),  {59'd0, sram_addr},  {59'd0, pa});
                if (pw) chk($sformatf("v%0d_din", i), {31'd0, sram_din}, {31'd0, par(pd), pd});
            end else begin
                chk($sformatf("v%0d_csb_n", i), {63'd0, sram_csb_n}, 64'd1);
                chk($sformatf("v%0d_we_n", i),  {63'd0, sram_we_n},  64'd1);
            end
            prev = vt[i];
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        // Reset lands one cycle after a port 1 read grant; the read must never return.
        @(posedge clk); #1 drive(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 1));
        @(negedge clk);
        chk("mid_gnt1", {63'd0, r1_gnt}, 64'd1);
        @(posedge clk); #1 drive(idle);
        reset = 1'b1;
        sb.delete();
        #1 chk_reset_vals("mid");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rv", {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
            @(posedge clk);
        end

        // Spare-bit handling: write 1, then read it back with the spare column flipped.
        #1 drive(mk(1, 1, 3, 32'h00000001, 0, 0, 0, 0, 1, 0));
        @(posedge clk); #1 drive(idle);
        @(negedge clk);
        chk("par_din32", {63'd0, sram_din[DW]}, {63'd0, par(32'h00000001)});
        @(posedge clk); #1 drive(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 0));
        flip_mask = 33'h1_0000_0000;
        @(posedge clk); #1 drive(idle);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (r0_rvalid) break;
        end
        chk("par_rvalid", {63'd0, r0_rvalid}, 64'd1);
        chk("par_err_rv", {63'd0, parity_err}, {63'd0, par(32'h00000001)});
        repeat (3) @(posedge clk);
        flip_mask = '0;
        @(negedge clk);
        chk("par_sticky", {63'd0, parity_err}, {63'd0, par(32'h00000001)});
        #1 reset = 1'b1;
        #1 chk("par_clear", {63'd0, parity_err}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
